// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the transmitter and receiver.
package uart_pkg;

  typedef enum logic {
    STOP_BITS_1 = 1'b0,
    STOP_BITS_2 = 1'b1
  } stop_bits_t;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_WAIT_HIGH
  } rx_state_t;

  // Out-of-range word lengths fall back to a full byte.
  function automatic logic [3:0] eff_data_bits(input logic [3:0] n);
    return (n == 4'd0 || n > 4'd8) ? 4'd8 : n;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input; resets to the idle (high) line level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver feeding the RX FIFO write port.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority around the bit centre.
//
// state        | meaning
// S_IDLE       | line idle, waiting for a low sample
// S_START      | validating start bit at its centre
// S_DATA       | shifting in data bits, LSB first
// S_PARITY     | checking the parity bit
// S_STOP1      | first stop bit
// S_STOP2      | second stop bit
// S_WAIT_HIGH  | line stuck low after a frame, waiting for idle
module uart_rx import uart_pkg::*; #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic       rx,
  output logic       rx_busy,
  output logic [7:0] rx_data,
  output logic       rx_wren,
  input  logic       rx_full,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  input  logic [3:0] num_data_bits,
  input  stop_bits_t stop_bits,
  input  parity_t    parity
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  rx_state_t    state;
  logic [CW-1:0] cnt;
  logic [7:0]   shreg;
  logic [3:0]   bitcnt;
  logic [3:0]   nbits;
  stop_bits_t   stop_cfg;
  parity_t      par_cfg;
  logic         par_err;
  logic         frm_err;
  logic         done;
  logic         rx_s;
  logic         bit_val;
  logic         at_dec;
  logic         at_last;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] DEC = CW'(OVERSAMPLE / 2);
  logic samp_early;
  logic samp_mid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_early <= 1'b1;
      samp_mid   <= 1'b1;
    end else if (sample_en) begin
      if (cnt == MID - 1'b1) samp_early <= rx_s;
      if (cnt == MID)        samp_mid   <= rx_s;
    end
  end

  assign bit_val = maj3(samp_early, samp_mid, rx_s);
`else
  localparam logic [CW-1:0] DEC = MID;
  assign bit_val = rx_s;
`endif

  assign at_dec  = sample_en && (cnt == DEC);
  assign at_last = sample_en && (cnt == LAST);
  assign rx_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      shreg         <= '0;
      bitcnt        <= '0;
      nbits         <= 4'd8;
      stop_cfg      <= STOP_BITS_1;
      par_cfg       <= PARITY_NONE;
      par_err       <= 1'b0;
      frm_err       <= 1'b0;
      done          <= 1'b0;
      rx_data       <= '0;
      rx_wren       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_wren       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      if (sample_en) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;

      if (done) begin
        // Completion cycle: errored frames are still delivered unless the FIFO is full.
        done <= 1'b0;
        cnt  <= '0;
        if (!rx_full) begin
          rx_wren       <= 1'b1;
          rx_data       <= shreg;
          rx_parity_err <= par_err;
          rx_frame_err  <= frm_err;
        end else begin
          rx_overrun <= 1'b1;
        end
        state <= rx_s ? S_IDLE : S_WAIT_HIGH;
      end else begin
        case (state)
          S_IDLE: begin
            if (sample_en && !rx_s) begin
              state <= S_START;
              cnt   <= '0;
            end
          end
          S_START: begin
            if (at_dec && bit_val) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else if (at_dec) begin
              nbits    <= eff_data_bits(num_data_bits);
              stop_cfg <= stop_bits;
              par_cfg  <= parity;
              shreg    <= '0;
              bitcnt   <= '0;
              par_err  <= 1'b0;
              frm_err  <= 1'b0;
            end else if (at_last) begin
              state <= S_DATA;
              cnt   <= '0;
            end
          end
          S_DATA: begin
            if (at_dec) begin
              shreg  <= {bit_val, shreg[7:1]};
              bitcnt <= bitcnt + 1'b1;
            end else if (at_last && bitcnt == nbits) begin
              // Right-justify short words so bit 0 is the first bit received.
              shreg <= shreg >> (4'd8 - nbits);
              state <= (par_cfg != PARITY_NONE) ? S_PARITY : S_STOP1;
              cnt   <= '0;
            end
          end
          S_PARITY: begin
            if (at_dec) begin
              par_err <= (par_cfg == PARITY_EVEN) ? (bit_val != ^shreg) : (bit_val != ~^shreg);
            end else if (at_last) begin
              state <= S_STOP1;
              cnt   <= '0;
            end
          end
          S_STOP1: begin
            if (at_dec) begin
              if (!bit_val) frm_err <= 1'b1;
              if (stop_cfg == STOP_BITS_1) done <= 1'b1;
            end else if (at_last) begin
              state <= S_STOP2;
              cnt   <= '0;
            end
          end
          S_STOP2: begin
            if (at_dec) begin
              if (!bit_val) frm_err <= 1'b1;
              done <= 1'b1;
            end
          end
          S_WAIT_HIGH: begin
            if (sample_en && rx_s) begin
              state <= S_IDLE;
              cnt   <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-built frames, counted monitor events, explicit expected values.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       rx = 1'b1;
  logic       rx_full = 1'b0;
  logic       rx_busy;
  logic [7:0] rx_data;
  logic       rx_wren;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic [3:0] num_data_bits = 4'd8;
  stop_bits_t stop_bits = STOP_BITS_1;
  parity_t    parity = PARITY_NONE;

  int div = 1;
  int div_cnt = 0;
  int checks = 0;
  int failures = 0;
  int wren_cnt = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] data_q[$];
  int w0, p0, f0, o0;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_en     (sample_en),
    .rx            (rx),
    .rx_busy       (rx_busy),
    .rx_data       (rx_data),
    .rx_wren       (rx_wren),
    .rx_full       (rx_full),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .num_data_bits (num_data_bits),
    .stop_bits     (stop_bits),
    .parity        (parity)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    sample_en = (div_cnt == 0);
    div_cnt   = (div_cnt + 1 >= div) ? 0 : div_cnt + 1;
  end

  always @(posedge clk) begin
    #1;
    if (rx_wren) begin
      wren_cnt++;
      data_q.push_back(rx_data);
      if (rx_parity_err) perr_cnt++;
      if (rx_frame_err) ferr_cnt++;
    end
    if (rx_overrun) ovr_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int got = 0;
    int guard = 0;
    while (got < n && guard < n * 8 + 16) begin
      @(posedge clk);
      guard++;
      if (sample_en) got++;
    end
    if (got < n) check_val("tick_timeout", got, n);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(16);
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    wait_ticks(n);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit has_par,
                            input logic pbit, input int nstop, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pbit);
    for (int i = 0; i < nstop; i++) drive_bit(stop_val);
  endtask

  task automatic snap();
    w0 = wren_cnt; p0 = perr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_val("reset_busy", rx_busy, 0);
    check_val("reset_wren", rx_wren, 0);
    check_val("reset_data", rx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle_ticks(20);

    // 8N1 0xA5
    snap();
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1);
    idle_ticks(32);
    check_val("a5_wren", wren_cnt - w0, 1);
    check_val("a5_data", rx_data, 8'hA5);
    check_val("a5_perr", perr_cnt - p0, 0);
    check_val("a5_ferr", ferr_cnt - f0, 0);
    check_val("a5_busy", rx_busy, 0);

    // 7E2 0x35: even parity bit is 0
    num_data_bits = 4'd7; parity = PARITY_EVEN; stop_bits = STOP_BITS_2;
    snap();
    send_frame(8'h35, 7, 1, 1'b0, 2, 1'b1);
    idle_ticks(32);
    check_val("7e2_data", rx_data, 8'h35);
    check_val("7e2_perr", perr_cnt - p0, 0);
    snap();
    send_frame(8'h35, 7, 1, 1'b1, 2, 1'b1);
    idle_ticks(32);
    check_val("7e2_bad_wren", wren_cnt - w0, 1);
    check_val("7e2_bad_perr", perr_cnt - p0, 1);

    // 8N1 0x3C with a low stop bit and a long break
    num_data_bits = 4'd8; parity = PARITY_NONE; stop_bits = STOP_BITS_1;
    snap();
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b0);
    rx = 1'b0;
    wait_ticks(40 * 16);
    @(negedge clk);
    check_val("brk_wren", wren_cnt - w0, 1);
    check_val("brk_ferr", ferr_cnt - f0, 1);
    check_val("brk_data", rx_data, 8'h3C);
    check_val("brk_state", 32'(dut.state), 32'(S_WAIT_HIGH));
    idle_ticks(32);
    check_val("brk_release", 32'(dut.state), 32'(S_IDLE));
    check_val("brk_no_second", wren_cnt - w0, 1);

    // Short low glitch on an idle line
    snap();
    rx = 1'b0;
    wait_ticks(6);
    @(negedge clk);
    idle_ticks(40);
    check_val("glitch_wren", wren_cnt - w0, 0);
    check_val("glitch_busy", rx_busy, 0);

`ifdef UART_RX_MAJORITY_EN
    // 0x00 frame with a one-tick high spike near the centre of data bit 3
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rx = 1'b0; wait_ticks(8); @(negedge clk);
        rx = 1'b1; wait_ticks(1); @(negedge clk);
        rx = 1'b0; wait_ticks(7); @(negedge clk);
      end else begin
        drive_bit(1'b0);
      end
    end
    drive_bit(1'b1);
    idle_ticks(32);
    check_val("spike_wren", wren_cnt - w0, 1);
    check_val("spike_data", rx_data, 8'h00);
`endif

    // Overrun: reload 0xA5, then drop 0x55 against a full FIFO
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1);
    idle_ticks(32);
    snap();
    rx_full = 1'b1;
    send_frame(8'h55, 8, 0, 1'b0, 1, 1'b1);
    idle_ticks(32);
    rx_full = 1'b0;
    idle_ticks(16);
    check_val("ovr_pulse", ovr_cnt - o0, 1);
    check_val("ovr_wren", wren_cnt - w0, 0);
    check_val("ovr_data", rx_data, 8'hA5);

    // Back-to-back 8O1 at sample_en every 4th clock; odd parity bit is 1 for both bytes
    div = 4; div_cnt = 0;
    num_data_bits = 4'd8; parity = PARITY_ODD; stop_bits = STOP_BITS_1;
    idle_ticks(8);
    snap();
    data_q.delete();
    send_frame(8'h00, 8, 1, 1'b1, 1, 1'b1);
    send_frame(8'hFF, 8, 1, 1'b1, 1, 1'b1);
    idle_ticks(32);
    check_val("b2b_wren", wren_cnt - w0, 2);
    check_val("b2b_perr", perr_cnt - p0, 0);
    check_val("b2b_first", (data_q.size() > 0) ? data_q[0] : 8'hEE, 8'h00);
    check_val("b2b_second", (data_q.size() > 1) ? data_q[1] : 8'hEE, 8'hFF);

    // Async reset in the middle of a frame
    parity = PARITY_NONE;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("mrst_busy", rx_busy, 0);
    check_val("mrst_data", rx_data, 8'h00);
    check_val("mrst_wren", rx_wren, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_ticks(32);
    snap();
    send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b1);
    idle_ticks(32);
    check_val("post_rst_wren", wren_cnt - w0, 1);
    check_val("post_rst_data", rx_data, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
